// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: data-memory port between the load/store stage
// (master) and the data-memory responder (slave).
//   master drives: addr, write_data, read_en, write_en, data_mask
//   slave drives : read_data, read_valid, fault, fault_addr
interface data_mem_responder_if;

    logic [31:0] i_data_mem_addr;
    logic [31:0] i_data_mem_write_data;
    logic        i_data_mem_read_en;
    logic        i_data_mem_write_en;
    logic [1:0]  i_data_mem_data_mask;
    logic [31:0] o_data_mem_read_data;
    logic        o_data_mem_read_valid;
    logic        o_data_mem_fault;
    logic [31:0] o_data_mem_fault_addr;

    modport master (
        output i_data_mem_addr,
        output i_data_mem_write_data,
        output i_data_mem_read_en,
        output i_data_mem_write_en,
        output i_data_mem_data_mask,
        input  o_data_mem_read_data,
        input  o_data_mem_read_valid,
        input  o_data_mem_fault,
        input  o_data_mem_fault_addr
    );

    modport slave (
        input  i_data_mem_addr,
        input  i_data_mem_write_data,
        input  i_data_mem_read_en,
        input  i_data_mem_write_en,
        input  i_data_mem_data_mask,
        output o_data_mem_read_data,
        output o_data_mem_read_valid,
        output o_data_mem_fault,
        output o_data_mem_fault_addr
    );

endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: synchronous data memory with byte-lane store steering,
// right-aligned zero-filled loads (1-cycle latency) and fault reporting.
// Ports: clk, rst (sync, active-high), bus (data_mem_responder_if.slave).
// Parameters: DEPTH_WORDS (power of two, >= 2), BASE_ADDR (byte addr of word 0).
// Macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of
// being forced onto the aligned lane.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);

    localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    logic [31:0] mem [DEPTH_WORDS];

    size_e       size;
    logic [31:0] offset;
    logic [IW-1:0] idx;
    logic [1:0]  lane;
    logic [1:0]  eff_lane;
    logic        below_base;
    logic        above_top;
    logic        out_of_range;
    logic        misalign;

    logic        access;
    logic        fault_c;
    logic        store_go;
    logic        load_go;

    logic [3:0]  byte_en;
    logic [31:0] wdata_lanes;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] rd_result;

    logic [31:0] read_data_q;
    logic        read_valid_q;
    logic        fault_q;
    logic [31:0] fault_addr_q;

    assign size       = size_e'(bus.i_data_mem_data_mask);
    assign offset     = bus.i_data_mem_addr - BASE_ADDR;
    assign idx        = offset[IW+1:2];
    assign lane       = offset[1:0];
    assign below_base = bus.i_data_mem_addr < BASE_ADDR;
    // Any set bit above the word index means offset >= 4*DEPTH_WORDS.
    assign above_top    = |offset[31:IW+2];
    assign out_of_range = below_base | above_top;

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        eff_lane = lane;
        misalign = 1'b0;
        unique case (size)
            SZ_HALF: misalign = lane[0];
            SZ_WORD: misalign = |lane;
            default: misalign = 1'b0;
        endcase
    end
`else
    // Low lane bits are dropped so half/word accesses snap to alignment.
    always_comb begin
        eff_lane = lane;
        misalign = 1'b0;
        unique case (size)
            SZ_HALF: eff_lane = {lane[1], 1'b0};
            SZ_WORD: eff_lane = 2'b00;
            default: eff_lane = lane;
        endcase
    end
`endif

    // Access qualification. A cycle with rst high performs nothing.
    // With both enables the store wins and the load is dropped.
    assign access   = ~rst
                    & (bus.i_data_mem_read_en | bus.i_data_mem_write_en)
                    & (size != SZ_NONE);
    assign fault_c  = access & (out_of_range | misalign);
    assign store_go = access & bus.i_data_mem_write_en & ~fault_c;
    assign load_go  = access & bus.i_data_mem_read_en
                    & ~bus.i_data_mem_write_en;

    // Store steering: replicate the right-aligned datum across the word
    // and let the byte enables pick the target lanes.
    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = '0;
        unique case (size)
            SZ_BYTE: begin
                byte_en     = 4'b0001 << eff_lane;
                wdata_lanes = {4{bus.i_data_mem_write_data[7:0]}};
            end
            SZ_HALF: begin
                byte_en     = 4'b0011 << eff_lane;
                wdata_lanes = {2{bus.i_data_mem_write_data[15:0]}};
            end
            SZ_WORD: begin
                byte_en     = 4'b1111;
                wdata_lanes = bus.i_data_mem_write_data;
            end
            default: begin
                byte_en     = 4'b0000;
                wdata_lanes = '0;
            end
        endcase
    end

    // Load alignment: shift the addressed lane down, zero-fill above.
    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {eff_lane, 3'b000};

    always_comb begin
        rd_result = '0;
        unique case (size)
            SZ_BYTE: rd_result = {24'h0, rd_shift[7:0]};
            SZ_HALF: rd_result = {16'h0, rd_shift[15:0]};
            SZ_WORD: rd_result = rd_shift;
            default: rd_result = '0;
        endcase
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (store_go) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            read_valid_q <= load_go;
            fault_q      <= fault_c;
            if (load_go) begin
                read_data_q <= fault_c ? 32'h0 : rd_result;
            end
            if (fault_c) begin
                fault_addr_q <= bus.i_data_mem_addr;
            end
        end
    end

    // A load result landing in a reset cycle is discarded.
    assign bus.o_data_mem_read_data  = read_data_q;
    assign bus.o_data_mem_read_valid = read_valid_q & ~rst;
    assign bus.o_data_mem_fault      = fault_q;
    assign bus.o_data_mem_fault_addr = fault_addr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed stimulus with a queue-based scoreboard;
// a negedge monitor pops expected load data / fault addresses.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS(4096),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] exp_data_q [$];
    logic [31:0] exp_fault_q [$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_data_mem_read_valid === 1'b1) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read_valid: got data %h expected no response",
                         bus.o_data_mem_read_data);
            end else begin
                chk("read_data", bus.o_data_mem_read_data, exp_data_q.pop_front());
            end
        end
        if (bus.o_data_mem_fault === 1'b1) begin
            if (exp_fault_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fault: got addr %h expected no fault",
                         bus.o_data_mem_fault_addr);
            end else begin
                chk("fault_addr", bus.o_data_mem_fault_addr, exp_fault_q.pop_front());
            end
        end
    end

    task automatic acc(input logic rd, input logic wr, input logic [1:0] m,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic ev, input logic [31:0] ed, input logic ef);
        bus.i_data_mem_read_en    = rd;
        bus.i_data_mem_write_en   = wr;
        bus.i_data_mem_data_mask  = m;
        bus.i_data_mem_addr       = a;
        bus.i_data_mem_write_data = wd;
        if (ev) exp_data_q.push_back(ed);
        if (ef) exp_fault_q.push_back(a);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) acc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_read_data"},  bus.o_data_mem_read_data, 32'h0);
        chk({tag, "_read_valid"}, {31'h0, bus.o_data_mem_read_valid}, 32'h0);
        chk({tag, "_fault"},      {31'h0, bus.o_data_mem_fault}, 32'h0);
        chk({tag, "_fault_addr"}, bus.o_data_mem_fault_addr, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_data_mem_read_en    = 1'b0;
        bus.i_data_mem_write_en   = 1'b0;
        bus.i_data_mem_data_mask  = 2'b00;
        bus.i_data_mem_addr       = 32'h0;
        bus.i_data_mem_write_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs("reset");

        // word store then load next cycle
        acc(0, 1, 2'b11, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        acc(1, 0, 2'b11, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);

        // byte stores (upper garbage must be ignored), then sub-word loads
        acc(0, 1, 2'b01, 32'h20, 32'hAAAAAA11, 0, 0, 0);
        acc(0, 1, 2'b01, 32'h21, 32'hBBBBBB22, 0, 0, 0);
        acc(0, 1, 2'b01, 32'h22, 32'hCCCCCC33, 0, 0, 0);
        acc(0, 1, 2'b01, 32'h23, 32'hDDDDDD44, 0, 0, 0);
        acc(1, 0, 2'b11, 32'h20, 32'h0, 1, 32'h44332211, 0);
        acc(1, 0, 2'b01, 32'h22, 32'h0, 1, 32'h00000033, 0);
        acc(1, 0, 2'b10, 32'h22, 32'h0, 1, 32'h00004433, 0);
        acc(1, 0, 2'b01, 32'h21, 32'h0, 1, 32'h00000022, 0);
        acc(1, 0, 2'b10, 32'h20, 32'h0, 1, 32'h00002211, 0);

        // half stores over an all-ones word
        acc(0, 1, 2'b11, 32'h30, 32'hFFFFFFFF, 0, 0, 0);
        acc(0, 1, 2'b10, 32'h30, 32'h1234CAFE, 0, 0, 0);
        acc(1, 0, 2'b11, 32'h30, 32'h0, 1, 32'hFFFFCAFE, 0);
        acc(0, 1, 2'b10, 32'h32, 32'h0000BEEF, 0, 0, 0);
        acc(1, 0, 2'b11, 32'h30, 32'h0, 1, 32'hBEEFCAFE, 0);

        // misaligned accesses
        acc(0, 1, 2'b11, 32'h40, 32'h0, 0, 0, 0);
        acc(0, 1, 2'b11, 32'h44, 32'h0, 0, 0, 0);
        acc(0, 1, 2'b11, 32'h41, 32'h55667788, 0, 0, TRAP);
        acc(0, 1, 2'b10, 32'h47, 32'h00009999, 0, 0, TRAP);
        acc(1, 0, 2'b11, 32'h40, 32'h0, 1, TRAP ? 32'h0 : 32'h55667788, 0);
        acc(1, 0, 2'b11, 32'h44, 32'h0, 1, TRAP ? 32'h0 : 32'h99990000, 0);
        acc(1, 0, 2'b11, 32'h42, 32'h0, 1, TRAP ? 32'h0 : 32'h55667788, TRAP);
        acc(1, 0, 2'b01, 32'h43, 32'h0, 1, TRAP ? 32'h0 : 32'h00000055, 0);

        // mask 00: no access at all
        acc(0, 1, 2'b00, 32'h10, 32'h0, 0, 0, 0);
        acc(1, 0, 2'b00, 32'h10, 32'h0, 0, 0, 0);
        acc(1, 0, 2'b11, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);

        // read+write together: store happens, load dropped
        acc(1, 1, 2'b11, 32'h50, 32'h11111111, 0, 0, 0);
        acc(1, 0, 2'b11, 32'h50, 32'h0, 1, 32'h11111111, 0);

        // out of range: store suppressed, load returns 0 with fault
        acc(0, 1, 2'b11, 32'h0, 32'hA5A5A5A5, 0, 0, 0);
        acc(0, 1, 2'b11, 32'h4000, 32'h12345678, 0, 0, 1);
        acc(1, 0, 2'b11, 32'h0, 32'h0, 1, 32'hA5A5A5A5, 0);
        acc(1, 0, 2'b11, 32'h4000, 32'h0, 1, 32'h0, 1);
        acc(1, 0, 2'b01, 32'hFFFF_FFFC, 32'h0, 1, 32'h0, 1);
        idle(3);
        @(negedge clk);
        chk("fault_addr_hold", bus.o_data_mem_fault_addr, 32'hFFFF_FFFC);
        chk("fault_idle", {31'h0, bus.o_data_mem_fault}, 32'h0);
        @(posedge clk);
        #1;

        // load followed by reset: result discarded, store in rst cycle ignored
        acc(1, 0, 2'b11, 32'h10, 32'h0, 0, 0, 0);
        rst = 1'b1;
        acc(0, 1, 2'b11, 32'h10, 32'h0, 0, 0, 0);
        rst = 1'b0;
        bus.i_data_mem_write_en = 1'b0;
        chk_reset_outputs("post_reset");
        acc(1, 0, 2'b11, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);
        acc(1, 0, 2'b11, 32'h20, 32'h0, 1, 32'h44332211, 0);
        idle(3);

        chk("pending_reads", exp_data_q.size(), 32'd0);
        chk("pending_faults", exp_fault_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Synchronous data-memory responder on the far side of the load/store stage's data-memory port. Accepts address, write data, read/write enables and the 2-bit size mask, and performs byte-lane steering for sub-word stores. Returns loads right-aligned and zero-filled with one cycle of latency, so the load/store stage can sign- or zero-extend bits [7:0]/[15:0] directly. Detects misaligned and out-of-range accesses and reports them as faults.

## Interface
Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words in the array; must be a power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- i_data_mem_addr  input  32  byte address
- i_data_mem_write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- i_data_mem_read_en  input  1  load request this cycle
- i_data_mem_write_en  input  1  store request this cycle
- i_data_mem_data_mask  input  2  size: 01 byte, 10 half, 11 word, 00 no access
- o_data_mem_read_data  output  32  load result, right-aligned, upper bits zero
- o_data_mem_read_valid  output  1  read_data valid this cycle
- o_data_mem_fault  output  1  one-cycle pulse: previous-cycle access faulted
- o_data_mem_fault_addr  output  32  byte address of most recent faulting access

## Operation
- Offset = addr − BASE_ADDR; word index = offset[31:2]; lane = offset[1:0].
- Out of range: offset ≥ 4·DEPTH_WORDS, or addr < BASE_ADDR.
- Store with mask 01: byte [7:0] written to lane; other bytes untouched.
- Store with mask 10: half [15:0] written to bytes lane, lane+1; other bytes untouched.
- Store with mask 11: full word written.
- Load: word read, shifted right by 8·lane, masked to 8/16/32 bits, zero-filled above.
- Mask 00 with either enable: no access, no read_valid, no fault.
- read_en and write_en both high: store performed, load dropped (read_valid stays 0), no fault.
- Faulting access: store suppressed (array unchanged); load returns read_data = 0 with read_valid = 1; fault pulses; fault_addr updated.
- Misalignment rules are governed by the configuration macro (see Configuration).
- Array contents are not reset.

## Timing
- Store issued at cycle N is committed at edge ending N; a load issued at N+1 to the same word returns the new value at N+2.
- Load issued at N: read_data/read_valid registered, presented during N+1, held only that cycle. read_valid is 0 otherwise; read_data holds its last value when read_valid is 0.
- Back-to-back loads: one result per cycle, in order.
- Fault for an access at N: fault high during N+1. fault_addr loads at that same edge and holds until the next fault.
- rst asserted at edge E: after E, read_data = 0, read_valid = 0, fault = 0, fault_addr = 0. Any access presented in the cycle with rst high is ignored: no store, no read_valid, no fault.
- An in-flight load result due in the cycle after rst is discarded.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - half with lane[0]=1 faults.
  - word with lane≠0 faults.
  - Byte accesses never misalign.
- DMEM_MISALIGN_TRAP_EN undefined:
  - lane low bits are forced aligned: half uses lane & 2'b10, word uses lane 0.
  - No misalignment faults; only out-of-range accesses fault.

## Test plan
- Word write 32'hDEADBEEF @0x10, then word read @0x10 next cycle: read_valid at N+2, read_data = 32'hDEADBEEF, fault 0.
- Byte writes 0x11/0x22/0x33/0x44 to 0x20..0x23, then word read @0x20: 32'h44332211. Byte read @0x22: 32'h00000033. Half read @0x22: 32'h00004433.
- Half write 16'hCAFE @0x30 over word 32'hFFFFFFFF: word read returns 32'hFFFFCAFE.
- With DMEM_MISALIGN_TRAP_EN, word write @0x41: array unchanged, fault pulse N+1, fault_addr = 0x41. Without the macro, the same write lands @0x40 and no fault is raised.
- Read at BASE_ADDR + 4·DEPTH_WORDS: read_valid 1, read_data 0, fault 1, fault_addr equals that address.
- Load issued, rst asserted the following cycle: read_valid stays 0; all outputs 0 after reset; earlier-written data still readable.
